// File: rtl/global_history.sv
// -----------------------------------------------------------------------------
// global_history
//
// Global branch-history manager for the IF stage. Keeps a speculative history
// that shifts in each predicted direction at fetch, and an architectural
// history that shifts in each resolved outcome. A FIFO of per-branch history
// snapshots hands the resolving stage the exact index its branch was predicted
// with. On a mispredict, the speculative history is repaired in one cycle and
// all in-flight snapshots are flushed.
//
// Parameters
//   H_width : history length in bits (2..8)
//   DEPTH   : in-flight snapshot capacity (power of two, 2..16)
//
// Ports
//   clk            in   rising-edge clock
//   rst            in   asynchronous, active-low reset
//   load_stall     in   IF frozen; blocks push
//   pred_valid     in   conditional branch predicted in IF this cycle
//   pred_taken     in   predicted direction
//   history        out  speculative history to the predictor
//   commit_valid   in   oldest in-flight branch resolved this cycle
//   commit_taken   in   actual outcome of that branch
//   mispredict     in   resolved direction differed (qualified by commit_valid)
//   commit_history out  snapshot at FIFO head (0 when empty), combinational
//   arch_history   out  committed history
//   stall_req      out  FIFO full; IF must hold
//   empty          out  no branches in flight
//   count          out  number of in-flight snapshots
//   underflow      out  sticky: commit seen while empty
// -----------------------------------------------------------------------------
module global_history #(
  parameter int H_width = 2,
  parameter int DEPTH   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load_stall,
  input  logic                     pred_valid,
  input  logic                     pred_taken,
  output logic [H_width-1:0]       history,
  input  logic                     commit_valid,
  input  logic                     commit_taken,
  input  logic                     mispredict,
  output logic [H_width-1:0]       commit_history,
  output logic [H_width-1:0]       arch_history,
  output logic                     stall_req,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     underflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [H_width-1:0] fifo_mem [DEPTH];
  logic [PW-1:0]      head_reg, tail_reg;
  logic [CW-1:0]      count_reg, count_next;
  logic [H_width-1:0] history_reg, arch_reg;
  logic               stall_reg, empty_reg, underflow_reg;

  logic push, pop, flush;

  // A resolving mispredict always wins over a same-cycle fetch: the fetched
  // branch is on the wrong path and must not leave a snapshot behind.
  assign push  = pred_valid & ~load_stall & ~stall_reg & ~(commit_valid & mispredict);
  assign pop   = commit_valid & ~empty_reg;
  assign flush = pop & mispredict;

  always_comb begin
    count_next = count_reg;
    if (push && !pop) begin
      count_next = count_reg + CW'(1);
    end else if (pop && !push) begin
      count_next = count_reg - CW'(1);
    end
  end

  // Snapshot storage has no reset; entries are only read while counted valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[tail_reg] <= history_reg;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_reg      <= '0;
      tail_reg      <= '0;
      count_reg     <= '0;
      history_reg   <= '0;
      arch_reg      <= '0;
      stall_reg     <= 1'b0;
      empty_reg     <= 1'b1;
      underflow_reg <= 1'b0;
    end else begin
      if (commit_valid && empty_reg) begin
        underflow_reg <= 1'b1;
      end
      if (pop) begin
        arch_reg <= {arch_reg[H_width-2:0], commit_taken};
      end
      if (flush) begin
        // Repair from the snapshot the mispredicted branch was fetched with,
        // followed by its true outcome.
        history_reg <= {commit_history[H_width-2:0], commit_taken};
        head_reg    <= '0;
        tail_reg    <= '0;
        count_reg   <= '0;
        empty_reg   <= 1'b1;
        stall_reg   <= 1'b0;
      end else begin
        if (push) begin
          tail_reg    <= tail_reg + PW'(1);
          history_reg <= {history_reg[H_width-2:0], pred_taken};
        end
        if (pop) begin
          head_reg <= head_reg + PW'(1);
        end
        count_reg <= count_next;
        empty_reg <= (count_next == '0);
        stall_reg <= (count_next == CW'(DEPTH));
      end
    end
  end

  assign history        = history_reg;
  assign arch_history   = arch_reg;
  assign count          = count_reg;
  assign stall_req      = stall_reg;
  assign empty          = empty_reg;
  assign underflow      = underflow_reg;
  assign commit_history = empty_reg ? '0 : fifo_mem[head_reg];

endmodule
